// File: rtl/trng_pkg.sv
// Shared constants and types for the TRNG post-processing tile.
package trng_pkg;

  // Output word width; this tile is byte-oriented only.
  localparam int unsigned BYTE_W = 8;

  // Default repetition-count cutoff (legal range 2..255).
  localparam int unsigned RCT_CUTOFF_DEFAULT = 32;

  // RCT counter width for the default cutoff.
  localparam int unsigned RCT_CNT_W = $clog2(RCT_CUTOFF_DEFAULT + 1);

  // Packer bit counter must hold 0..BYTE_W inclusive.
  localparam int unsigned PACK_CNT_W = $clog2(BYTE_W + 1);

  // Von Neumann pair phase.
  typedef enum logic {
    VN_IDLE,
    VN_HAVE_FIRST
  } vn_phase_e;

endpackage

// File: rtl/trng_postproc_if.sv
// Valid/ready byte stream from the post-processor to the output mux.
interface trng_postproc_if;
  import trng_pkg::*;

  logic [BYTE_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/trng_vn_debias.sv
// Von Neumann debiaser with raw-bit bypass; emits at most one bit per accepted sample.
module trng_vn_debias
  import trng_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic acc,
  input  logic raw_bit,
  input  logic vn_bypass,
  output logic bit_valid,
  output logic bit_out
);

  vn_phase_e phase_q, phase_d;
  logic      stored_q, stored_d;

  // Phase and first-of-pair storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= VN_IDLE;
      stored_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      stored_q <= stored_d;
    end
  end

  // Pair decode; bypass forces the phase idle so a half pair is discarded on toggle.
  always_comb begin
    phase_d   = phase_q;
    stored_d  = stored_q;
    bit_valid = 1'b0;
    bit_out   = stored_q;
    if (vn_bypass) begin
      phase_d   = VN_IDLE;
      bit_valid = acc;
      bit_out   = raw_bit;
    end else if (acc) begin
      unique case (phase_q)
        VN_IDLE: begin
          stored_d = raw_bit;
          phase_d  = VN_HAVE_FIRST;
        end
        VN_HAVE_FIRST: begin
          phase_d   = VN_IDLE;
          bit_valid = (stored_q != raw_bit);
        end
        default: phase_d = VN_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/trng_postproc.sv
// TRNG post-processor: VN debias, repetition-count health test, byte packer, output register.
module trng_postproc
  import trng_pkg::*;
#(
  parameter int unsigned RCT_CUTOFF = RCT_CUTOFF_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   raw_bit,
  input  logic                   raw_valid,
  input  logic                   vn_bypass,
  trng_postproc_if.master        out,
  output logic                   health_fail,
  output logic                   overflow
);

  localparam int unsigned RctW = $clog2(RCT_CUTOFF + 1);
  localparam logic [PACK_CNT_W-1:0] CntFull = PACK_CNT_W'(BYTE_W);
  localparam logic [PACK_CNT_W-1:0] CntLast = PACK_CNT_W'(BYTE_W - 1);

  logic acc;
  logic bit_valid, bit_out;

  logic [RctW-1:0]       rct_cnt_q, rct_cnt_d;
  logic                  rct_prev_q, rct_prev_d;
  logic                  health_fail_q, health_fail_d;
  logic [BYTE_W-1:0]     shreg_q, shreg_d, shreg_next;
  logic [PACK_CNT_W-1:0] cnt_q, cnt_d;
  logic [BYTE_W-1:0]     out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  overflow_q, overflow_d;
  logic                  can_load;

  assign acc = en & raw_valid & ~health_fail_q;

  trng_vn_debias u_vn (
    .clk       (clk),
    .rst       (rst),
    .acc       (acc),
    .raw_bit   (raw_bit),
    .vn_bypass (vn_bypass),
    .bit_valid (bit_valid),
    .bit_out   (bit_out)
  );

  // Repetition-count test on the raw (pre-debias) stream; count 0 means no previous bit.
  always_comb begin
    rct_cnt_d     = rct_cnt_q;
    rct_prev_d    = rct_prev_q;
    health_fail_d = health_fail_q;
    if (acc) begin
      rct_prev_d = raw_bit;
      if (rct_cnt_q == '0 || raw_bit != rct_prev_q) begin
        rct_cnt_d = RctW'(1);
      end else if (rct_cnt_q != '1) begin
        rct_cnt_d = rct_cnt_q + RctW'(1);
        if (rct_cnt_d == RctW'(RCT_CUTOFF)) health_fail_d = 1'b1;
      end
    end
  end

  // Packer and output register; a full byte goes straight to the output when it is free.
  always_comb begin
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    overflow_d  = overflow_q;
    can_load    = ~out_valid_q | out.out_ready;
    shreg_next  = {shreg_q[BYTE_W-2:0], bit_out};
    if (health_fail_q) begin
      shreg_d     = '0;
      cnt_d       = '0;
      out_data_d  = '0;
      out_valid_d = 1'b0;
    end else begin
      if (out_valid_q && out.out_ready) out_valid_d = 1'b0;
      if (cnt_q == CntFull) begin
        if (can_load) begin
          out_data_d  = shreg_q;
          out_valid_d = 1'b1;
          cnt_d       = '0;
          if (bit_valid) begin
            shreg_d = shreg_next;
            cnt_d   = PACK_CNT_W'(1);
          end
        end else if (bit_valid) begin
          overflow_d = 1'b1;
        end
      end else if (bit_valid) begin
        shreg_d = shreg_next;
        if (cnt_q == CntLast && can_load) begin
          out_data_d  = shreg_next;
          out_valid_d = 1'b1;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + PACK_CNT_W'(1);
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rct_cnt_q     <= '0;
      rct_prev_q    <= 1'b0;
      health_fail_q <= 1'b0;
      shreg_q       <= '0;
      cnt_q         <= '0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      rct_cnt_q     <= rct_cnt_d;
      rct_prev_q    <= rct_prev_d;
      health_fail_q <= health_fail_d;
      shreg_q       <= shreg_d;
      cnt_q         <= cnt_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      overflow_q    <= overflow_d;
    end
  end

  assign out.out_data  = out_data_q;
  assign out.out_valid = out_valid_q;
  assign health_fail   = health_fail_q;
  assign overflow      = overflow_q;

endmodule

// File: doc/trng_postproc.md
Name: trng_postproc

Overview:
- Post-processing stage directly downstream of the raw entropy source.
- Consumes one synchronized raw bit per strobe and applies a von Neumann debiaser.
- Runs a repetition-count health test on the raw stream.
- Packs debiased bits into bytes and presents them on a valid/ready interface to the top-level output mux (uo_out).

Parameters:
- RCT_CUTOFF, 32: number of consecutive identical raw bits that declares a source failure; legal range 2..255.
- BYTE_W, 8: output word width; fixed at 8 for this tile.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- en  in  1  block enable; when low, raw samples are ignored and all state holds
- raw_bit  in  1  raw entropy bit from source
- raw_valid  in  1  one-cycle strobe qualifying raw_bit
- vn_bypass  in  1  1 = pass raw bits straight to packer (health test still active)
- out_data  out  8  packed random byte
- out_valid  out  1  out_data holds an unconsumed byte
- out_ready  in  1  consumer accepts byte when out_valid & out_ready
- health_fail  out  1  sticky RCT failure flag
- overflow  out  1  sticky flag: a debiased bit was dropped due to backpressure

Behaviour:
- Reset (rst=1 at posedge) clears all state: out_data=0x00, out_valid=0, health_fail=0, overflow=0, VN phase=0, packer count=0, RCT count=0. Reset overrides every other input, including mid-byte and mid-pair.
- Sample accept: acc = en & raw_valid & ~health_fail.
- VN debiaser:
  - phase=0 on acc: store bit, phase←1.
  - phase=1 on acc: phase←0; if stored≠raw_bit, emit the stored bit, so (0,1)→0 and (1,0)→1; (0,0) and (1,1) emit nothing.
  - Bypass: every acc emits raw_bit and phase is held at 0. Toggling vn_bypass mid-pair discards the stored bit (phase←0).
- Packer:
  - shreg←{shreg[6:0],bit} and cnt++ per emitted bit; first bit lands in the MSB.
  - When cnt reaches 8, the byte is full.
  - The full byte moves to the output register in the same cycle if the register is empty or is being consumed that cycle; cnt←0.
  - Otherwise the packer holds the full byte; further emitted bits are dropped and overflow←1.
- Latency: out_valid rises one clock after the cycle the 8th bit is emitted.
- Output: out_data and out_valid are registered. A handshake (out_valid & out_ready) clears out_valid unless a full packer byte refills it in the same cycle, giving back-to-back bytes with no bubble.
- RCT:
  - First acc after reset: rct_cnt←1, prev←raw_bit.
  - Equal bit: rct_cnt saturating increment. Differing bit: rct_cnt←1.
  - When the increment makes rct_cnt==RCT_CUTOFF, health_fail←1 on that edge.
  - Counter width is $clog2(RCT_CUTOFF+1).
- health_fail=1: sticky until rst. Forces out_valid←0 and out_data←0x00 next cycle, discards the packer contents, and blocks all acc.
- en=0: no acc; an existing out_valid byte may still be consumed.

Decomposition:
- trng_pkg:
  - BYTE_W constant.
  - RCT_CUTOFF default.
  - Localparam for RCT counter width.
  - Enum for VN phase (VN_IDLE, VN_HAVE_FIRST).
- Sub-module trng_vn_debias: inputs acc, raw_bit, vn_bypass; outputs bit_valid, bit_out. Contains the phase/stored-bit state.
- Packer, RCT and output register live in trng_postproc.

Test Plan:
- Bypass byte: vn_bypass=1, out_ready=1, feed 1,0,1,1,0,0,1,0 one strobe each → out_data=0xB2, out_valid=1 for exactly 1 cycle, one clock after the 8th strobe.
- VN pairs: vn_bypass=0, feed pairs (0,1),(1,0),(0,0),(1,1) repeated until 8 bits emitted → out_data=0x55; discarded pairs never change cnt.
- RCT trip: RCT_CUTOFF=32, feed 32 ones → health_fail=1 after the 32nd strobe. Then out_valid=0 and out_data=0x00, further strobes are ignored, and only rst clears the flag.
- RCT near miss: 31 ones, then a 0, then 31 ones → health_fail stays 0.
- Backpressure: out_ready=0, bypass, feed 24 bits. Byte 1 is held in out_data, byte 2 is held in the packer, bits 17-24 are dropped, overflow=1. Raise out_ready → bytes 1 and 2 delivered on consecutive cycles.
- Reset mid-operation: rst asserted after 5 packed bits and an out_valid byte pending → next cycle all outputs are 0. The following 8 bypass bits form a fresh byte containing none of the old bits.
